// File: rtl/apb_cfg_pkg.sv
// rtl/apb_cfg_pkg.sv - shared types and constants for the APB to cfg strobe bridge
package apb_cfg_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} apb_cfg_state_e;

  localparam int unsigned APB_CFG_ERR_RDATA = 0;
  localparam int unsigned APB_CFG_IDX_SHIFT = 2;

endpackage

// File: rtl/apb_cfg_timeout.sv
// rtl/apb_cfg_timeout.sv - load/count/expire counter bounding the read wait (used under APB_CFG_TIMEOUT_EN)
module apb_cfg_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // expire_o marks the last permitted wait cycle, so the caller errors out on that edge
  assign expire_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (count_i && !expire_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/apb_cfg_bridge.sv
// rtl/apb_cfg_bridge.sv - APB3 slave issuing one cfg wr/rd strobe per transfer; APB_CFG_TIMEOUT_EN adds read timeout
module apb_cfg_bridge
  import apb_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_wr,
  output logic                  cfg_rd,
  input  logic [DATA_WIDTH-1:0] cfg_rdata,
  input  logic                  cfg_rdata_vld
);

  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(APB_CFG_ERR_RDATA);

  apb_cfg_state_e        state_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [ADDR_WIDTH-1:0] cfg_addr_q;
  logic [DATA_WIDTH-1:0] cfg_wdata_q;
  logic                  cfg_wr_q;
  logic                  cfg_rd_q;
  logic                  timeout;
  logic                  misaligned;

  assign misaligned = |paddr[APB_CFG_IDX_SHIFT-1:0];

`ifdef APB_CFG_TIMEOUT_EN
  apb_cfg_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .load_i   (state_q == ISSUE),
    .count_i  (state_q == RWAIT),
    .expire_o (timeout)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Strobes, pready, pslverr and prdata default low each cycle so they pulse only where set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      prdata_q    <= ERR_RDATA;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      cfg_wr_q    <= 1'b0;
      cfg_rd_q    <= 1'b0;
    end else begin
      cfg_wr_q  <= 1'b0;
      cfg_rd_q  <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= ERR_RDATA;
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            if (misaligned) begin
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              state_q   <= RESP;
            end else begin
              cfg_addr_q  <= paddr >> APB_CFG_IDX_SHIFT;
              cfg_wdata_q <= pwdata;
              write_q     <= pwrite;
              cfg_wr_q    <= pwrite;
              cfg_rd_q    <= !pwrite;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            pready_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            state_q  <= RWAIT;
          end
        end
        RWAIT: begin
          if (cfg_rdata_vld) begin
            prdata_q <= cfg_rdata;
            pready_q <= 1'b1;
            state_q  <= RESP;
          end else if (timeout) begin
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_wdata = cfg_wdata_q;
  assign cfg_wr    = cfg_wr_q;
  assign cfg_rd    = cfg_rd_q;

endmodule

// File: tb/tb_apb_cfg_bridge.sv
// tb/tb_apb_cfg_bridge.sv - directed scoreboard bench for apb_cfg_bridge with a two-cycle cfg model
module tb_apb_cfg_bridge;

  localparam int TC = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
  logic        cfg_wr, cfg_rd, cfg_rdata_vld;

  logic [31:0] mem [0:255];
  logic        rd_d1, mdl_vld, mute, inj_vld;
  logic [31:0] rdat_d1, mdl_rdata;
  int          wr_cnt, rd_cnt;
  int          errors, checks;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  apb_cfg_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_rdata(cfg_rdata), .cfg_rdata_vld(cfg_rdata_vld)
  );

  // cfg register file: write on strobe, read data valid two cycles after cfg_rd
  always @(posedge clk) begin
    if (cfg_wr) mem[cfg_addr[7:0]] <= cfg_wdata;
    rd_d1     <= cfg_rd;
    rdat_d1   <= mem[cfg_addr[7:0]];
    mdl_vld   <= rd_d1 & !mute;
    mdl_rdata <= rdat_d1;
  end
  assign cfg_rdata     = mdl_rdata;
  assign cfg_rdata_vld = mdl_vld | inj_vld;

  always @(negedge clk) begin
    if (cfg_wr) wr_cnt <= wr_cnt + 1;
    if (cfg_rd) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int k, wr0, rd0;
    logic aligned;
    aligned = (addr[1:0] == 2'b00);
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    wr0 = wr_cnt; rd0 = rd_cnt;
    @(posedge clk); #1;
    penable = 1'b1;
    k = 1;
    check("t1_cfg_wr", 32'(cfg_wr), 32'(aligned & wr));
    check("t1_cfg_rd", 32'(cfg_rd), 32'(aligned & !wr));
    if (aligned) begin
      check("t1_cfg_addr", cfg_addr, addr >> 2);
      if (wr) check("t1_cfg_wdata", cfg_wdata, wdata);
    end
    while (!pready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    e = sb.pop_front();
    check("pready", 32'(pready), 32'd1);
    check("latency", 32'(k), 32'(e.lat));
    check("prdata", prdata, e.rdata);
    check("pslverr", 32'(pslverr), 32'(e.err));
    check("strobe_off_at_resp", 32'({cfg_wr, cfg_rd}), 32'd0);
    check("wr_strobes", 32'(wr_cnt - wr0), 32'(aligned & wr));
    check("rd_strobes", 32'(rd_cnt - rd0), 32'(aligned & !wr));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    errors = 0; checks = 0; wr_cnt = 0; rd_cnt = 0;
    mute = 1'b0; inj_vld = 1'b0;
    rd_d1 = 1'b0; mdl_vld = 1'b0; rdat_d1 = '0; mdl_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata", prdata, 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_cfg_addr", cfg_addr, 32'd0);
    check("rst_cfg_wdata", cfg_wdata, 32'd0);
    check("rst_cfg_wr", 32'(cfg_wr), 32'd0);
    check("rst_cfg_rd", 32'(cfg_rd), 32'd0);
    rstn = 1'b1;
    idle(2);

    xfer(1'b1, 32'h08, 32'h12345678, 32'h0, 1'b0, 2);
    idle(2);
    xfer(1'b0, 32'h08, 32'h0, 32'h12345678, 1'b0, 4);
    idle(1);
    xfer(1'b1, 32'h0A, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    check("misaligned_addr_kept", cfg_addr, 32'd2);
    xfer(1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1);

    xfer(1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    xfer(1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 4);
    xfer(1'b1, 32'h44, 32'h0BADC0DE, 32'h0, 1'b0, 2);
    xfer(1'b0, 32'h08, 32'h0, 32'h12345678, 1'b0, 4);
    idle(1);

    inj_vld = 1'b1;
    @(posedge clk); #1;
    inj_vld = 1'b0;
    check("spurious_vld_pready", 32'(pready), 32'd0);
    @(posedge clk); #1;
    check("spurious_vld_pready2", 32'(pready), 32'd0);

`ifdef APB_CFG_TIMEOUT_EN
    mute = 1'b1;
    xfer(1'b0, 32'h8C, 32'h0, 32'h0, 1'b1, 2 + TC);
    idle(1);
    inj_vld = 1'b1;
    @(posedge clk); #1;
    inj_vld = 1'b0;
    check("late_vld_pready", 32'(pready), 32'd0);
    check("late_vld_prdata", prdata, 32'd0);
    @(posedge clk); #1;
    check("late_vld_pready2", 32'(pready), 32'd0);
    mute = 1'b0;
    xfer(1'b0, 32'h44, 32'h0, 32'h0BADC0DE, 1'b0, 4);
`endif

    mute = 1'b1;
    idle(1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("rwait_rst_prdata", prdata, 32'd0);
    check("rwait_rst_pready", 32'(pready), 32'd0);
    check("rwait_rst_pslverr", 32'(pslverr), 32'd0);
    check("rwait_rst_cfg_addr", cfg_addr, 32'd0);
    check("rwait_rst_cfg_wdata", cfg_wdata, 32'd0);
    check("rwait_rst_strobes", 32'({cfg_wr, cfg_rd}), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    mute = 1'b0;
    idle(2);
    xfer(1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 4);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_cfg_bridge.md
# apb_cfg_bridge

APB3 slave that converts processor register accesses into the single-cycle `wr`/`rd` strobe protocol used by the `cfg` register block, which sits directly downstream. The bridge latches each APB transfer and converts the byte address to a word index. It issues exactly one write or read strobe per transfer, then holds the APB access phase with `pready` low until the write is done or the delayed read data returns. Misaligned accesses and (optionally) read timeouts complete with `pslverr`.

## Interface
- `ADDR_WIDTH`, 32, APB and cfg address width
- `DATA_WIDTH`, 32, data width
- `TIMEOUT_CYCLES`, 16, max cycles spent in RWAIT before error completion (≥2)

- `clk` in 1 — single clock
- `rstn` in 1 — asynchronous, active-low reset
- `psel` in 1 — APB select
- `penable` in 1 — APB access phase
- `pwrite` in 1 — 1 = write
- `paddr` in ADDR_WIDTH — byte address
- `pwdata` in DATA_WIDTH — write data
- `prdata` out DATA_WIDTH — read data, valid with `pready`
- `pready` out 1 — transfer complete
- `pslverr` out 1 — error, valid with `pready`
- `cfg_addr` out ADDR_WIDTH — word index `{2'b0, paddr[ADDR_WIDTH-1:2]}`
- `cfg_wdata` out DATA_WIDTH — write data to cfg
- `cfg_wr` out 1 — one-cycle write strobe
- `cfg_rd` out 1 — one-cycle read strobe
- `cfg_rdata` in DATA_WIDTH — read data from cfg
- `cfg_rdata_vld` in 1 — one-cycle read-data valid from cfg

## Operation
- FSM states:
  - **IDLE**
    - setup phase sampled (`psel & ~penable`), `paddr[1:0]==0` → capture addr/wdata/pwrite → ISSUE.
    - setup phase sampled, `paddr[1:0]!=0` → RESP with error; no cfg strobe.
  - **ISSUE**: one cycle, `cfg_wr` or `cfg_rd` high; write → RESP, read → RWAIT.
  - **RWAIT**
    - `cfg_rdata_vld` → capture `cfg_rdata` into `prdata` → RESP.
    - timeout → RESP with error, `prdata`=0.
  - **RESP**: `pready`=1 for exactly one cycle → IDLE.
- All outputs registered.
- `cfg_addr`/`cfg_wdata` stay stable from ISSUE until the next capture.
- `prdata` is 0 for writes and error responses; `pslverr` is 0 except on misalignment or timeout.
- `cfg_rdata_vld` outside RWAIT (late or spurious) is ignored.
- `psel` dropping before `pready` (protocol violation): the bridge still finishes the cfg strobe and passes through RESP; no hang.
- Reset (asynchronous, any state): FSM → IDLE.
  - Output reset values: `prdata`=0, `pready`=0, `pslverr`=0, `cfg_addr`=0, `cfg_wdata`=0, `cfg_wr`=0, `cfg_rd`=0.
  - Timeout counter cleared.

## Timing
- T0 = cycle in which the setup phase is sampled.
- Write: `cfg_wr` high in T1; `pready` high in T2 (one APB wait state).
- Read against cfg (two-cycle read latency): `cfg_rd` in T1, RWAIT from T2, `cfg_rdata_vld` in T3, `pready`+`prdata` in T4.
- Misaligned: `pready`+`pslverr` in T1, no wait state.
- Timeout: RWAIT lasts at most `TIMEOUT_CYCLES` cycles (T2…T(1+TIMEOUT_CYCLES)); error response in T(2+TIMEOUT_CYCLES). With default 16, that is T18.
- `cfg_rdata_vld` in the last RWAIT cycle wins over timeout.
- Back-to-back: a setup phase in the cycle after RESP is accepted. There is never more than one cfg strobe per APB transfer.

## Configuration
- `APB_CFG_TIMEOUT_EN` defined: the RWAIT timeout counter ($clog2(TIMEOUT_CYCLES+1) bits, cleared on RWAIT entry) and timeout error path are present.
- Not defined: RWAIT waits indefinitely for `cfg_rdata_vld`; `TIMEOUT_CYCLES` is unused; the counter is not synthesized.

## Structure
- Shared package `apb_cfg_pkg` holds:
  - state enum (IDLE, ISSUE, RWAIT, RESP);
  - `APB_CFG_ERR_RDATA` = 0;
  - `APB_CFG_IDX_SHIFT` = 2.
- One sub-module is natural: `apb_cfg_timeout`, a load/count/expire counter instantiated only under `APB_CFG_TIMEOUT_EN`.

## Test plan
- Write `paddr`=0x08, `pwdata`=0x12345678 → `cfg_addr`=2 and `cfg_wr` high in T1 only; `pready`=1, `pslverr`=0 in T2.
- Read `paddr`=0x08 with cfg model returning 0x12345678 at two-cycle latency → `cfg_rd` in T1; `prdata`=0x12345678, `pready` in T4.
- Write `paddr`=0x0A → `pready`=1, `pslverr`=1 in T1; `cfg_wr`/`cfg_rd` never asserted.
- With `APB_CFG_TIMEOUT_EN`, read 0x8C, model never returns valid → `pready`=1, `pslverr`=1, `prdata`=0 in T18. A `cfg_rdata_vld` pulse in T20 is ignored; FSM remains IDLE.
- Back-to-back write 0x40 then read 0x40 with no idle cycle → second setup accepted the cycle after the first RESP; read returns the written value; exactly one strobe per transfer.
- Assert `rstn` low during RWAIT → all outputs 0 immediately. After release, a new read completes normally.
